// File: rtl/seg_scan_pkg.sv
// Shared constants for the six-digit multiplexed seven-segment scanner.
// Segment codes are active-low, bit0 = a ... bit6 = g.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam int unsigned SEC_LO = 0;
  localparam int unsigned SEC_HI = 1;
  localparam int unsigned MIN_LO = 2;
  localparam int unsigned MIN_HI = 3;
  localparam int unsigned HR_LO  = 4;
  localparam int unsigned HR_HI  = 5;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the active-low pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes go dark.
module bcd_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver with frame-synchronous display updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digit 5 when it holds zero.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] digit_in,
  input  logic [5:0]  dp_in,
  input  logic        load,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [5:0]  an_n,
  output logic        frame_done
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST    = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_START = PW'(BLANK_CYC);
  localparam logic [2:0]    LAST_IDX    = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] prescaler;
  logic [2:0]    index;
  logic [23:0]   dispDigits, pendDigits;
  logic [5:0]    dispDp, pendDp;
  logic          pending;

  logic          preWrap, boundary;
  logic [3:0]    nib;
  logic          dpSel;
  logic [6:0]    segRaw, segNext;
  logic          dpNext;
  logic [5:0]    anNext;

  assign preWrap  = (prescaler == PRE_LAST);
  assign boundary = preWrap && (index == LAST_IDX);

  always_comb begin
    nib   = 4'd0;
    dpSel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (index == 3'(i)) begin
        nib   = dispDigits[i*4 +: 4];
        dpSel = dispDp[i];
      end
    end
  end

  bcd_to_seg uSeg (
    .bcd (nib),
    .seg (segRaw)
  );

  always_comb begin
    segNext = segRaw;
    dpNext  = ~dpSel;
`ifdef LEADING_ZERO_BLANK_EN
    if (index == 3'(HR_HI) && nib == 4'd0) begin
      segNext = SEG_OFF;
      dpNext  = 1'b1;
    end
`endif
  end

  always_comb begin
    anNext = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (index == 3'(i) && prescaler >= BLANK_START) anNext[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      index      <= '0;
      pending    <= 1'b0;
      dispDigits <= '0;
      dispDp     <= '0;
      pendDigits <= '0;
      pendDp     <= '0;
      an_n       <= '1;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (preWrap) begin
        prescaler <= '0;
        index     <= (index == LAST_IDX) ? 3'd0 : index + 3'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end

      // Display only changes on the frame boundary, so a frame is never torn.
      if (boundary) begin
        if (load) begin
          dispDigits <= digit_in;
          dispDp     <= dp_in;
        end else if (pending) begin
          dispDigits <= pendDigits;
          dispDp     <= pendDp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pendDigits <= digit_in;
        pendDp     <= dp_in;
        pending    <= 1'b1;
      end

      frame_done <= boundary;
      an_n       <= anNext;
      seg_n      <= segNext;
      dp_n       <= dpNext;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=8, BLANK_CYC=2) against a cycle-count model.
module tb_seg_scan_driver;

  localparam int unsigned SD    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = SD * 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [23:0] digit_in = '0;
  logic [5:0]  dp_in = '0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  an_n;
  logic        frame_done;

  seg_scan_driver #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .dp_in      (dp_in),
    .load       (load),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  int k = 0;  // clock edges since reset release

  logic [23:0] mDisp = '0;
  logic [5:0]  mDp = '0;
  logic [23:0] mPendD = '0;
  logic [5:0]  mPendP = '0;
  bit          mPend = 1'b0;

  logic [6:0] segRef [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic rstTick(input bit ld);
    rst = 1'b1;
    load = ld;
    digit_in = 24'($urandom());
    dp_in = 6'($urandom());
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("rst_an_n", {2'b0, an_n}, 8'h3F);
    chk("rst_seg_n", {1'b0, seg_n}, 8'h7F);
    chk("rst_dp_n", {7'b0, dp_n}, 8'h01);
    chk("rst_frame_done", {7'b0, frame_done}, 8'h00);
    k = 0;
    mDisp = '0;
    mDp = '0;
    mPendD = '0;
    mPendP = '0;
    mPend = 1'b0;
  endtask

  task automatic tick(input bit ld, input logic [23:0] d, input logic [5:0] p);
    int unsigned pos, slot;
    logic [3:0] nib;
    logic [5:0] eAn;
    logic [6:0] eSeg;
    logic       eDp, eFd;
    rst = 1'b0;
    load = ld;
    digit_in = d;
    dp_in = p;
    pos  = k % SD;
    slot = (k / SD) % 6;
    eAn = 6'h3F;
    if (pos >= BC) eAn[slot] = 1'b0;
    nib  = mDisp[slot*4 +: 4];
    eSeg = (nib <= 4'd9) ? segRef[nib] : 7'h7F;
    eDp  = ~mDp[slot];
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 5 && nib == 4'd0) begin
      eSeg = 7'h7F;
      eDp  = 1'b1;
    end
`endif
    eFd = ((k % FRAME) == FRAME - 1);
    if (eFd) begin
      if (ld) begin
        mDisp = d;
        mDp = p;
      end else if (mPend) begin
        mDisp = mPendD;
        mDp = mPendP;
      end
      mPend = 1'b0;
    end else if (ld) begin
      mPendD = d;
      mPendP = p;
      mPend = 1'b1;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("an_n", {2'b0, an_n}, {2'b0, eAn});
    chk("seg_n", {1'b0, seg_n}, {1'b0, eSeg});
    chk("dp_n", {7'b0, dp_n}, {7'b0, eDp});
    chk("frame_done", {7'b0, frame_done}, {7'b0, eFd});
    k++;
  endtask

  task automatic idleToBoundary();
    while ((k % FRAME) != FRAME - 1) tick(1'b0, 24'h0, 6'h0);
  endtask

  initial begin
    repeat (3) rstTick(1'b0);

    // Free run: anode order, blanking and frame pulse on reset data.
    repeat (FRAME) tick(1'b0, 24'h0, 6'h0);

    // Mid-frame load held until the boundary, then shown for a full frame.
    repeat (10) tick(1'b0, 24'h0, 6'h0);
    tick(1'b1, 24'h235959, 6'b010100);
    while (k < 3 * FRAME) tick(1'b0, 24'h0, 6'h0);

    // Overwritten pending data, then a load on the boundary cycle itself.
    repeat (4) tick(1'b0, 24'h0, 6'h0);
    tick(1'b1, 24'h111111, 6'h3F);
    repeat (7) tick(1'b0, 24'h0, 6'h0);
    tick(1'b1, 24'h222222, 6'h01);
    idleToBoundary();
    tick(1'b1, 24'h000000, 6'h00);
    repeat (FRAME) tick(1'b0, 24'h0, 6'h0);

    // Non-decimal nibble in slot 3.
    tick(1'b1, 24'h00A000, 6'h08);
    idleToBoundary();
    repeat (FRAME + 1) tick(1'b0, 24'h0, 6'h0);

    // Leading zero in digit 5.
    tick(1'b1, 24'h012345, 6'h00);
    idleToBoundary();
    repeat (FRAME + 1) tick(1'b0, 24'h0, 6'h0);

    // Random loads at random cycles, including boundary coincidences.
    repeat (6 * FRAME) begin
      if ($urandom_range(0, 15) == 0) tick(1'b1, 24'($urandom()), 6'($urandom()));
      else tick(1'b0, 24'h0, 6'h0);
    end

    // Reset mid-slot (slot 3, prescaler 5) with a coincident load to be dropped.
    tick(1'b1, 24'h987654, 6'h2A);
    while ((k % FRAME) != 3 * SD + 5) tick(1'b0, 24'h0, 6'h0);
    rstTick(1'b1);
    repeat (FRAME + 8) tick(1'b0, 24'h0, 6'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (1 kHz slot rate at 50 MHz); legal range 8..2^20.
REQ-002 SHALL have parameter BLANK_CYC, default 4, anode-off cycles at the start of each slot; legal range 1..SCAN_DIV-1.
REQ-003 SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port digit_in  in  24  six BCD nibbles: [3:0] sec lo, [7:4] sec hi, [11:8] min lo, [15:12] min hi, [19:16] hr lo, [23:20] hr hi.
REQ-006 SHALL have port dp_in  in  6  decimal-point request per digit, active-high, same index order.
REQ-007 SHALL have port load  in  1  one-cycle strobe that captures digit_in and dp_in.
REQ-008 SHALL have port seg_n  out  7  shared segment bus, active-low, bit0 = a ... bit6 = g.
REQ-009 SHALL have port dp_n  out  1  shared decimal point, active-low.
REQ-010 SHALL have port an_n  out  6  digit enables, active-low; at most one bit low at any time.
REQ-011 SHALL have port frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL count a prescaler 0..SCAN_DIV-1 that wraps to 0; on wrap, the digit index SHALL advance 0->1->...->5->0.
REQ-013 SHALL register seg_n, dp_n and an_n, giving 1-cycle latency from prescaler/index state to pins.
REQ-014 SHALL drive an_n[index] low only while prescaler >= BLANK_CYC; all other an_n bits, and every bit during blanking, SHALL be high.
REQ-015 SHALL drive seg_n/dp_n from the display register nibble and dp bit selected by index.
REQ-016 SHALL output segments all off (7'h7F) for any nibble value 10..15.
REQ-017 SHALL write load data into a pending register and set a pending flag; a later load before the boundary SHALL overwrite the pending data.
REQ-018 SHALL define the frame boundary as the cycle in which index wraps 5->0; on that cycle, if pending is set, the display register SHALL take the pending data and pending SHALL clear.
REQ-019 SHALL, when load coincides with the boundary cycle, write that cycle's digit_in/dp_in directly into the display register and clear pending.
REQ-020 SHALL assert frame_done for exactly one cycle, registered and coincident with the display-register update of REQ-018/019, whether or not an update occurs.
REQ-021 SHALL never change the display register mid-frame, so no torn frames are produced.

Reset
REQ-022 SHALL, while rst is high, set: prescaler=0, index=0, pending=0, display and pending registers=0, an_n=6'h3F, seg_n=7'h7F, dp_n=1, frame_done=0.
REQ-023 SHALL, when rst is asserted mid-slot, blank all anodes on the next edge and restart at index 0, prescaler 0 after release; a load in the same cycle as rst SHALL be discarded.

Configuration
REQ-024 SHALL, when LEADING_ZERO_BLANK_EN is defined, output seg_n=7'h7F and dp_n=1 for digit 5 whenever its displayed nibble is 0; the anode timing is unchanged.
REQ-025 SHALL, when LEADING_ZERO_BLANK_EN is undefined, display digit 5 value 0 as "0" like every other digit.

Structure
REQ-026 SHALL place the following in shared package seg_scan_pkg: the 0-9 active-low segment table, SEG_OFF=7'h7F, NUM_DIGITS=6, and digit-index constants (SEC_LO..HR_HI).
REQ-027 SHALL implement BCD-to-segment conversion in one combinational sub-module, bcd_to_seg (4-bit in, 7-bit active-low out, blank on >9).

Verification (bench: SCAN_DIV=8, BLANK_CYC=2)
REQ-028 Reset then free-run 48 cycles -> each an_n bit low exactly 6 consecutive cycles per 8-cycle slot, order 0..5, never two low; frame_done pulses every 48 cycles.
REQ-029 load digit_in=24'h235959, dp_in=6'b010100 mid-frame -> old data held until frame_done; next frame shows 9,5,9,5,3,2 (slot 1 seg_n=7'h12, i.e. "5"), dp_n low in slots 2 and 4.
REQ-030 Two loads in one frame (24'h111111, then 24'h222222), plus a load on the boundary cycle (24'h000000) -> next frame shows only 000000; the boundary-cycle load is applied immediately.
REQ-031 Nibble 4'hA in slot 3 -> seg_n=7'h7F during slot 3 while an_n[3] still goes low.
REQ-032 load 24'h012345 with LEADING_ZERO_BLANK_EN defined -> slot 5 seg_n=7'h7F; with it undefined -> slot 5 seg_n=7'h40 ("0").
REQ-033 rst pulsed during slot 3, prescaler=5 -> an_n=6'h3F the next cycle, display register=0, scan restarts at slot 0 after release.
